// File: rtl/rndgen_pkg.sv
// Shared constants and types for the random-number generator family.
// rnd_m uses the LFSR parameter sets; rnd_word_m uses the word/VN entries.
package rndgen_pkg;

  // LFSR parameter sets used by rnd_m.
  localparam int unsigned RND_LFSR_W16   = 16;
  localparam logic [15:0] RND_TAPS_W16   = 16'hB400;
  localparam int unsigned RND_LFSR_W32   = 32;
  localparam logic [31:0] RND_TAPS_W32   = 32'h8020_0003;

  // Default payload width of a packed random word.
  localparam int unsigned RND_WORD_W_DEF = 8;

  // Von Neumann corrector state: waiting for first or second bit of a pair.
  typedef enum logic {
    VN_IDLE = 1'b0,
    VN_HALF = 1'b1
  } vn_state_e;

endpackage : rndgen_pkg

// File: rtl/rnd_fifo_m.sv
// Small synchronous FIFO holding packed random words.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   push, data_in      write request and data; ignored when full unless popping
//   full               cnt == DEPTH
//   pop, data_out      read request and head entry; ignored when empty
//   empty              cnt == 0
//   cnt                entries currently stored
module rnd_fifo_m #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             do_push_c;
  logic             do_pop_c;

  assign full     = (cnt_q == CNTW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign cnt      = cnt_q;
  assign data_out = mem_q[rd_q];

  // A push into a full FIFO is accepted only when the head leaves this cycle.
  always_comb begin
    do_pop_c  = pop & ~empty;
    do_push_c = push & (~full | do_pop_c);
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    if (do_push_c) wr_d = wr_q + PW'(1);
    if (do_pop_c)  rd_d = rd_q + PW'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push_c) mem_q[wr_q] <= data_in;
    end
  end

endmodule : rnd_fifo_m

// File: rtl/rnd_word_m.sv
// Packs the serial random bit stream into WIDTH-bit words, optionally
// debiased by a von Neumann corrector, and offers them on valid/ready.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   bit_in, bit_vld     serial random bit and its qualifier
//   flush               discard partial word and pending VN bit
//   word_out, word_vld  head-of-FIFO word and valid
//   word_rdy            consumer accept
//   fifo_cnt            words buffered
//   drop_cnt            words lost to a full FIFO (saturating)
module rnd_word_m
  import rndgen_pkg::*;
#(
  parameter int unsigned WIDTH  = RND_WORD_W_DEF,
  parameter int unsigned DEPTH  = 2,
  parameter bit          VN_EN  = 1'b0,
  parameter int unsigned DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_in,
  input  logic                       bit_vld,
  input  logic                       flush,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_vld,
  input  logic                       word_rdy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned CNTW = $clog2(DEPTH+1);

  vn_state_e         vn_q, vn_d;
  logic              vn_bit_q, vn_bit_d;
  logic [WIDTH-2:0]  shreg_q, shreg_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              pay_vld_c;
  logic              pay_bit_c;
  logic [WIDTH-1:0]  word_c;
  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic              empty_c;
  logic [CNTW-1:0]   cnt_c;

  // State registers for the VN corrector, packer and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_q     <= VN_IDLE;
      vn_bit_q <= 1'b0;
      shreg_q  <= '0;
      bcnt_q   <= '0;
      drop_q   <= '0;
    end else begin
      vn_q     <= vn_d;
      vn_bit_q <= vn_bit_d;
      shreg_q  <= shreg_d;
      bcnt_q   <= bcnt_d;
      drop_q   <= drop_d;
    end
  end

  // Payload bit source: raw bits, or VN pairs where 1,0 -> 1 and 0,1 -> 0.
  always_comb begin
    vn_d      = vn_q;
    vn_bit_d  = vn_bit_q;
    pay_vld_c = 1'b0;
    pay_bit_c = 1'b0;
    if (flush) begin
      vn_d = VN_IDLE;
    end else if (bit_vld) begin
      if (!VN_EN) begin
        pay_vld_c = 1'b1;
        pay_bit_c = bit_in;
      end else begin
        case (vn_q)
          VN_IDLE: begin
            vn_d     = VN_HALF;
            vn_bit_d = bit_in;
          end
          VN_HALF: begin
            vn_d = VN_IDLE;
            if (vn_bit_q != bit_in) begin
              pay_vld_c = 1'b1;
              pay_bit_c = vn_bit_q;
            end
          end
          default: vn_d = VN_IDLE;
        endcase
      end
    end
  end

  // MSB-first packer; the completing bit is pushed in the same cycle.
  always_comb begin
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    push_c  = 1'b0;
    word_c  = {shreg_q, pay_bit_c};
    if (flush) begin
      bcnt_d = '0;
    end else if (pay_vld_c) begin
      shreg_d = word_c[WIDTH-2:0];
      if (bcnt_q == CW'(WIDTH - 1)) begin
        push_c = 1'b1;
        bcnt_d = '0;
      end else begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end
  end

  // A completed word is dropped only if the FIFO is full and nothing leaves.
  always_comb begin
    pop_c  = word_rdy & ~empty_c;
    drop_d = drop_q;
    if (push_c && full_c && !pop_c && (drop_q != {DROP_W{1'b1}}))
      drop_d = drop_q + DROP_W'(1);
  end

  rnd_fifo_m #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_c),
    .data_in  (word_c),
    .full     (full_c),
    .pop      (word_rdy),
    .data_out (word_out),
    .empty    (empty_c),
    .cnt      (cnt_c)
  );

  assign word_vld = ~empty_c;
  assign fifo_cnt = cnt_c;
  assign drop_cnt = drop_q;

endmodule : rnd_word_m

// File: tb/tb_rnd_word_m.sv
// Bench for rnd_word_m: a raw-bit instance (WIDTH=8, DROP_W=2) and a
// von Neumann instance (WIDTH=4) run side by side against a queue model.
module tb_rnd_word_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit0, bit1, vld, flush, rdy;
  logic [7:0] word_out0;
  logic [3:0] word_out1;
  logic       word_vld0, word_vld1;
  logic [1:0] fifo_cnt0, fifo_cnt1;
  logic [1:0] drop_cnt0;
  logic [15:0] drop_cnt1;

  int checks = 0;
  int passed = 0;

  // Reference model state, index 0 = raw instance, 1 = VN instance.
  int m_w    [2] = '{8, 4};
  int m_vn   [2] = '{0, 1};
  int m_dmax [2] = '{3, 65535};
  int m_acc  [2];
  int m_nb   [2];
  int m_pend [2];
  int m_first[2];
  int m_fq   [2][2];
  int m_fn   [2];
  int m_drop [2];

  always #5 clk = ~clk;

  rnd_word_m #(.WIDTH(8), .DEPTH(2), .VN_EN(1'b0), .DROP_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit0), .bit_vld(vld), .flush(flush),
    .word_out(word_out0), .word_vld(word_vld0), .word_rdy(rdy),
    .fifo_cnt(fifo_cnt0), .drop_cnt(drop_cnt0)
  );

  rnd_word_m #(.WIDTH(4), .DEPTH(2), .VN_EN(1'b1), .DROP_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit1), .bit_vld(vld), .flush(flush),
    .word_out(word_out1), .word_vld(word_vld1), .word_rdy(rdy),
    .fifo_cnt(fifo_cnt1), .drop_cnt(drop_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0; m_nb[c] = 0; m_pend[c] = 0; m_first[c] = 0;
      m_fn[c] = 0; m_drop[c] = 0;
    end
  endtask

  // One clock of behaviour for channel c: pop, then derive payload, then push/drop.
  task automatic model_step(input int c, input int b, input int v, input int fl, input int r);
    int have, pay;
    have = 0; pay = 0;
    if (r != 0 && m_fn[c] > 0) begin
      m_fq[c][0] = m_fq[c][1];
      m_fn[c]--;
    end
    if (fl != 0) begin
      m_nb[c] = 0; m_acc[c] = 0; m_pend[c] = 0;
    end else if (v != 0) begin
      if (m_vn[c] == 0) begin
        have = 1; pay = b;
      end else if (m_pend[c] == 0) begin
        m_pend[c] = 1; m_first[c] = b;
      end else begin
        m_pend[c] = 0;
        if (m_first[c] != b) begin have = 1; pay = m_first[c]; end
      end
    end
    if (have != 0) begin
      m_acc[c] = ((m_acc[c] << 1) | pay) & ((1 << m_w[c]) - 1);
      m_nb[c]++;
      if (m_nb[c] == m_w[c]) begin
        if (m_fn[c] < 2) begin
          m_fq[c][m_fn[c]] = m_acc[c];
          m_fn[c]++;
        end else if (m_drop[c] < m_dmax[c]) begin
          m_drop[c]++;
        end
        m_nb[c] = 0; m_acc[c] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("vld0", 32'(word_vld0), 32'(m_fn[0] > 0));
    chk("cnt0", 32'(fifo_cnt0), 32'(m_fn[0]));
    chk("drop0", 32'(drop_cnt0), 32'(m_drop[0]));
    if (m_fn[0] > 0) chk("word0", 32'(word_out0), 32'(m_fq[0][0]));
    chk("vld1", 32'(word_vld1), 32'(m_fn[1] > 0));
    chk("cnt1", 32'(fifo_cnt1), 32'(m_fn[1]));
    chk("drop1", 32'(drop_cnt1), 32'(m_drop[1]));
    if (m_fn[1] > 0) chk("word1", 32'(word_out1), 32'(m_fq[1][0]));
  endtask

  // Drive one cycle, advance the model at the edge, sample 1 time unit later.
  task automatic cyc(input logic b0, input logic b1, input logic v, input logic fl, input logic r);
    bit0 = b0; bit1 = b1; vld = v; flush = fl; rdy = r;
    @(posedge clk);
    model_step(0, int'(b0), int'(v), int'(fl), int'(r));
    model_step(1, int'(b1), int'(v), int'(fl), int'(r));
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0]  pat8;
    logic [11:0] pat12;
    logic [7:0]  w1;
    logic [7:0]  fresh;
    logic        rb;

    rst_n = 1'b0; bit0 = 1'b0; bit1 = 1'b0; vld = 1'b0; flush = 1'b0; rdy = 1'b0;
    model_reset();
    #1;
    chk("rst_vld0", 32'(word_vld0), 32'd0);
    chk("rst_word0", 32'(word_out0), 32'd0);
    chk("rst_drop0", 32'(drop_cnt0), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #4;

    // Raw packing: 1,0,1,1,0,0,1,0 -> 8'hB2 visible for one cycle.
    pat8 = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      cyc(pat8[i], 1'b0, 1'b1, 1'b0, 1'b1);
      if (i > 0) chk("t1_early_vld", 32'(word_vld0), 32'd0);
    end
    chk("t1_vld", 32'(word_vld0), 32'd1);
    chk("t1_word", 32'(word_out0), 32'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_vld_gone", 32'(word_vld0), 32'd0);

    // VN pairs 10,01,11,10,00,10 -> payload 1,0,1,1 -> 4'hB after bit 12.
    pat12 = 12'b10_01_11_10_00_10;
    for (int i = 11; i >= 0; i--) begin
      cyc(1'b0, pat12[i], 1'b1, 1'b0, 1'b1);
      if (i > 0) chk("t2_early_vld", 32'(word_vld1), 32'd0);
    end
    chk("t2_vld", 32'(word_vld1), 32'd1);
    chk("t2_word", 32'(word_out1), 32'hB);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Four words into a stalled 2-deep FIFO: two kept, two dropped.
    w1 = '0;
    for (int i = 0; i < 32; i++) begin
      rb = 1'($urandom_range(0, 1));
      if (i < 8) w1 = {w1[6:0], rb};
      cyc(rb, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      if (i >= 8) chk("t3_hold", 32'(word_out0), 32'(w1));
    end
    chk("t3_cnt", 32'(fifo_cnt0), 32'd2);
    chk("t3_drop", 32'(drop_cnt0), 32'd2);
    chk("t3_head", 32'(word_out0), 32'(w1));
    drain();

    // Full FIFO with a pop in the completion cycle: no drop, count stays 2.
    for (int i = 0; i < 24; i++)
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, (i == 23));
    chk("t4_cnt", 32'(fifo_cnt0), 32'd2);
    chk("t4_drop", 32'(drop_cnt0), 32'd2);
    drain();

    // Flush after 5 bits; the next word uses only the 8 fresh bits.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    fresh = 8'($urandom_range(0, 255));
    for (int i = 7; i >= 0; i--) cyc(fresh[i], 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_word", 32'(word_out0), 32'(fresh));
    chk("t5_cnt", 32'(fifo_cnt0), 32'd1);

    // Saturate the 2-bit drop counter.
    for (int i = 0; i < 48; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_sat", 32'(drop_cnt0), 32'd3);
    drain();

    // Async reset mid-word with one word buffered.
    for (int i = 0; i < 11; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_pre_cnt", 32'(fifo_cnt0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_vld", 32'(word_vld0), 32'd0);
    chk("t6_cnt", 32'(fifo_cnt0), 32'd0);
    chk("t6_drop", 32'(drop_cnt0), 32'd0);
    chk("t6_word", 32'(word_out0), 32'd0);
    chk("t6_drop1", 32'(drop_cnt1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    for (int i = 0; i < 8; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_refill", 32'(word_vld0), 32'(i == 7));
    end
    drain();

    // Random traffic: sparse valid, rare flush, random ready.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
          1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_rnd_word_m
